// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA byte-packer write path.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wr_state_e;

    localparam int LEN_W          = 6;
    localparam int CNT_W          = LEN_W + 1;
    localparam int BYTES_PER_WORD = 4;

    // A programmed length of 0 stands for the full 64-word buffer.
    function automatic logic [CNT_W-1:0] decode_len(input logic [LEN_W-1:0] len);
        decode_len = (len == '0) ? CNT_W'(1 << LEN_W) : {1'b0, len};
    endfunction

endpackage

// File: rtl/dma_byte_packer_writer_word_fifo.sv
// Small synchronous FIFO holding packed words until the memory port takes them.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes all stored words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dma_byte_packer_writer.sv
// Packs a byte stream little-endian into 32-bit words and writes them to
// consecutive word addresses starting at the latched base address.
module dma_byte_packer_writer
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_start,
    input  logic [15:0]       i_RCC_DMA_ADDR_HIGH,
    input  logic [15:0]       i_RCC_DMA_ADDR_LOW,
    input  logic [LEN_W-1:0]  i_RCC_BUFFER_LENGTH,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic [ADDR_W-1:0] mem_WRITE_addr,
    output logic              mem_write_flag,
    output logic [31:0]       HWDATA_toMem,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_word_cnt
);

    wr_state_e          state;
    logic [CNT_W-1:0]   len_words;
    logic [CNT_W+1:0]   bytes_in;
    logic [CNT_W+1:0]   total_bytes;
    logic [1:0]         lane;
    logic [23:0]        pack;
    logic [ADDR_W-1:0]  base_addr;
    logic [31:0]        push_word;
    logic [31:0]        fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               byte_acc;
    logic               word_push;
    logic               fifo_pop;

    assign total_bytes    = {len_words, 2'b00};
    assign o_byte_ready   = (state == RUN) && !fifo_full && (bytes_in < total_bytes);
    assign byte_acc       = i_byte_valid && o_byte_ready;
    assign word_push      = byte_acc && (lane == 2'(BYTES_PER_WORD - 1));
    assign push_word      = {i_byte, pack};
    assign fifo_pop       = !fifo_empty && i_mem_ready;

    // Write port presents the FIFO head; address/data gated to zero while idle.
    assign mem_write_flag = !fifo_empty;
    assign mem_WRITE_addr = fifo_empty ? '0 : base_addr + ADDR_W'({o_word_cnt, 2'b00});
    assign HWDATA_toMem   = fifo_empty ? '0 : fifo_head;

    word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .push      (word_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Transfer FSM with lane, byte and word counters and registered status outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            len_words  <= '0;
            o_word_cnt <= '0;
            bytes_in   <= '0;
            lane       <= '0;
        end else begin
            o_done <= 1'b0;
            if (byte_acc) begin
                bytes_in <= bytes_in + 1'b1;
                lane     <= lane + 2'd1;
            end
            if (fifo_pop) o_word_cnt <= o_word_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= RUN;
                        o_busy     <= 1'b1;
                        len_words  <= decode_len(i_RCC_BUFFER_LENGTH);
                        o_word_cnt <= '0;
                        bytes_in   <= '0;
                        lane       <= '0;
                    end
                end
                RUN: begin
                    if (bytes_in == total_bytes) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Base address captured at start; the two low bits are forced to word alignment.
    always_ff @(posedge HCLK) begin
        if (state == IDLE && i_start)
            base_addr <= ADDR_W'({i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW} & 32'hFFFF_FFFC);
    end

    // Collect the first three bytes of a word; the fourth goes straight into the push.
    always_ff @(posedge HCLK) begin
        if (byte_acc) begin
            case (lane)
                2'd0:    pack[7:0]   <= i_byte;
                2'd1:    pack[15:8]  <= i_byte;
                2'd2:    pack[23:16] <= i_byte;
                default: pack        <= pack;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_byte_packer_writer.sv
// Directed bench for dma_byte_packer_writer: table of transfers plus
// hand-written stall, restart-ignore and reset-abort sequences.
module tb_dma_byte_packer_writer;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_RCC_DMA_ADDR_HIGH = '0;
    logic [15:0] i_RCC_DMA_ADDR_LOW = '0;
    logic [5:0]  i_RCC_BUFFER_LENGTH = '0;
    logic [7:0]  i_byte = '0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic [31:0] mem_WRITE_addr;
    logic        mem_write_flag;
    logic [31:0] HWDATA_toMem;
    logic        i_mem_ready = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [6:0]  o_word_cnt;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always #5 HCLK = ~HCLK;

    dma_byte_packer_writer #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
        .HCLK                (HCLK),
        .HRESETn             (HRESETn),
        .i_start             (i_start),
        .i_RCC_DMA_ADDR_HIGH (i_RCC_DMA_ADDR_HIGH),
        .i_RCC_DMA_ADDR_LOW  (i_RCC_DMA_ADDR_LOW),
        .i_RCC_BUFFER_LENGTH (i_RCC_BUFFER_LENGTH),
        .i_byte              (i_byte),
        .i_byte_valid        (i_byte_valid),
        .o_byte_ready        (o_byte_ready),
        .mem_WRITE_addr      (mem_WRITE_addr),
        .mem_write_flag      (mem_write_flag),
        .HWDATA_toMem        (HWDATA_toMem),
        .i_mem_ready         (i_mem_ready),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_word_cnt          (o_word_cnt)
    );

    typedef struct {
        logic [5:0]  len;
        logic [31:0] base;
        logic [7:0]  first;
        logic [7:0]  step;
        int          nwords;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
        logic [31:0] first_data;
        logic [31:0] last_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write-port monitor: records accepted writes, counts done pulses,
    // and checks that a stalled request holds address/data/flag.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_flag", 32'(mem_write_flag), 32'd1);
                check("hold_addr", mem_WRITE_addr, prev_addr);
                check("hold_data", HWDATA_toMem, prev_data);
            end
            if (mem_write_flag && i_mem_ready) begin
                wr_addr_q.push_back(mem_WRITE_addr);
                wr_data_q.push_back(HWDATA_toMem);
            end
            if (o_done) done_cnt++;
            hold_prev = mem_write_flag && !i_mem_ready;
            prev_addr = mem_WRITE_addr;
            prev_data = HWDATA_toMem;
        end
    end

    function automatic logic [7:0] byte_at(input logic [7:0] first, input logic [7:0] step, input int j);
        byte_at = first + 8'(j) * step;
    endfunction

    function automatic logic [31:0] word_at(input logic [7:0] first, input logic [7:0] step, input int k);
        word_at = {byte_at(first, step, 4*k+3), byte_at(first, step, 4*k+2),
                   byte_at(first, step, 4*k+1), byte_at(first, step, 4*k)};
    endfunction

    task automatic pulse_start(input logic [5:0] len, input logic [31:0] base);
        @(posedge HCLK); #1;
        i_start             = 1'b1;
        i_RCC_BUFFER_LENGTH = len;
        i_RCC_DMA_ADDR_HIGH = base[31:16];
        i_RCC_DMA_ADDR_LOW  = base[15:0];
        @(posedge HCLK); #1;
        i_start             = 1'b0;
        i_RCC_BUFFER_LENGTH = 6'h2A;
        i_RCC_DMA_ADDR_HIGH = 16'hDEAD;
        i_RCC_DMA_ADDR_LOW  = 16'hBEEF;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] first, input logic [7:0] step, input int offset);
        for (int i = 0; i < n; i++) begin
            int  t;
            logic acc;
            i_byte       = byte_at(first, step, offset + i);
            i_byte_valid = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 200) begin
                @(negedge HCLK);
                acc = o_byte_ready;
                t++;
            end
            if (!acc) begin
                check("byte_timeout", 32'd0, 32'd1);
                i_byte_valid = 1'b0;
                return;
            end
            @(posedge HCLK); #1;
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge HCLK);
            t++;
        end
        if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge HCLK);
        #1;
    endtask

    task automatic check_words(input int n, input logic [31:0] base, input logic [7:0] first, input logic [7:0] step);
        check("n_writes", 32'(wr_addr_q.size()), 32'(n));
        for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
            check($sformatf("addr[%0d]", k), wr_addr_q[k], (base & 32'hFFFF_FFFC) + 32'(4*k));
            check($sformatf("data[%0d]", k), wr_data_q[k], word_at(first, step, k));
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   d0;
        v = vecs[idx];
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        i_mem_ready = 1'b1;
        pulse_start(v.len, v.base);
        send_bytes(4 * v.nwords, v.first, v.step, 0);
        wait_done(d0);
        check_words(v.nwords, v.base, v.first, v.step);
        if (wr_addr_q.size() > 0) begin
            check("first_addr", wr_addr_q[0], v.first_addr);
            check("last_addr", wr_addr_q[wr_addr_q.size()-1], v.last_addr);
            check("first_data", wr_data_q[0], v.first_data);
            check("last_data", wr_data_q[wr_data_q.size()-1], v.last_data);
        end
        check("word_cnt", 32'(o_word_cnt), 32'(v.nwords));
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("busy_after", 32'(o_busy), 32'd0);
        check("flag_after", 32'(mem_write_flag), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
        check({tag, "_flag"}, 32'(mem_write_flag), 32'd0);
        check({tag, "_addr"}, mem_WRITE_addr, 32'd0);
        check({tag, "_data"}, HWDATA_toMem, 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_cnt"}, 32'(o_word_cnt), 32'd0);
    endtask

    initial begin
        int d0;

        vecs[0] = '{len: 6'd1, base: 32'h0000_1000, first: 8'h11, step: 8'h11, nwords: 1,
                    first_addr: 32'h0000_1000, last_addr: 32'h0000_1000,
                    first_data: 32'h4433_2211, last_data: 32'h4433_2211};
        vecs[1] = '{len: 6'd4, base: 32'h0000_1000, first: 8'h00, step: 8'h01, nwords: 4,
                    first_addr: 32'h0000_1000, last_addr: 32'h0000_100C,
                    first_data: 32'h0302_0100, last_data: 32'h0F0E_0D0C};
        vecs[2] = '{len: 6'd0, base: 32'h0000_2000, first: 8'h00, step: 8'h01, nwords: 64,
                    first_addr: 32'h0000_2000, last_addr: 32'h0000_20FC,
                    first_data: 32'h0302_0100, last_data: 32'hFFFE_FDFC};
        vecs[3] = '{len: 6'd3, base: 32'hFFFF_FFF8, first: 8'hA0, step: 8'h01, nwords: 3,
                    first_addr: 32'hFFFF_FFF8, last_addr: 32'h0000_0000,
                    first_data: 32'hA3A2_A1A0, last_data: 32'hABAA_A9A8};
        vecs[4] = '{len: 6'd2, base: 32'h0000_3007, first: 8'h40, step: 8'h02, nwords: 2,
                    first_addr: 32'h0000_3004, last_addr: 32'h0000_3008,
                    first_data: 32'h4644_4240, last_data: 32'h4E4C_4A48};

        // Reset state
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_outputs_zero("rst");
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        check_outputs_zero("post_rst");

        for (int i = 0; i < 5; i++) run_vec(i);

        // Backpressure: memory stalled while 16 bytes fill the FIFO
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        i_mem_ready = 1'b0;
        pulse_start(6'd8, 32'h0000_5000);
        send_bytes(16, 8'h80, 8'h01, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            check("stall_ready_low", 32'(o_byte_ready), 32'd0);
            check("stall_addr", mem_WRITE_addr, 32'h0000_5000);
            check("stall_data", HWDATA_toMem, 32'h8382_8180);
        end
        @(posedge HCLK); #1;
        fork
            send_bytes(16, 8'h80, 8'h01, 16);
            i_mem_ready = 1'b1;
        join
        wait_done(d0);
        check_words(8, 32'h0000_5000, 8'h80, 8'h01);
        check("stall_cnt", 32'(o_word_cnt), 32'd8);
        check("stall_done", 32'(done_cnt - d0), 32'd1);

        // A start pulse during RUN must not disturb the transfer in progress
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        i_mem_ready = 1'b1;
        pulse_start(6'd2, 32'h0000_6000);
        send_bytes(3, 8'h20, 8'h01, 0);
        check("restart_busy", 32'(o_busy), 32'd1);
        pulse_start(6'd5, 32'h0000_9000);
        send_bytes(5, 8'h20, 8'h01, 3);
        wait_done(d0);
        check_words(2, 32'h0000_6000, 8'h20, 8'h01);
        check("restart_cnt", 32'(o_word_cnt), 32'd2);
        check("restart_done", 32'(done_cnt - d0), 32'd1);
        i_byte_valid = 1'b1;
        @(negedge HCLK);
        check("idle_not_ready", 32'(o_byte_ready), 32'd0);
        #1 i_byte_valid = 1'b0;

        // Reset after 6 bytes of a 4-word transfer, then a clean transfer
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        i_mem_ready = 1'b0;
        pulse_start(6'd4, 32'h0000_7000);
        send_bytes(6, 8'h60, 8'h01, 0);
        check("pre_abort_flag", 32'(mem_write_flag), 32'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check_outputs_zero("abort");
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        i_mem_ready = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_no_write", 32'(wr_addr_q.size()), 32'd0);
        d0 = done_cnt;
        pulse_start(6'd1, 32'h0000_8000);
        send_bytes(4, 8'hC1, 8'h01, 0);
        wait_done(d0);
        check_words(1, 32'h0000_8000, 8'hC1, 8'h01);
        if (wr_data_q.size() > 0) check("clean_data", wr_data_q[0], 32'hC4C3_C2C1);
        check("clean_cnt", 32'(o_word_cnt), 32'd1);
        check("clean_done", 32'(done_cnt - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
